// File: rtl/prefix_adder_pkg.sv
// Shared helpers for the pipelined Sklansky prefix adder: level count and
// placement of pipeline registers between prefix levels.
package prefix_adder_pkg;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 128;

    function automatic int num_levels(int width);
        return $clog2(width);
    endfunction

    function automatic int ceil_div(int n, int d);
        return (n + d - 1) / d;
    endfunction

    // Stage index whose register sits right after prefix level lvl, or -1.
    // Level 0 is the p/g pre-processing; the output register (stage S-1) is not
    // reported here because it always follows the sum logic.
    function automatic int stage_after_level(int lvl, int L, int S);
        int st;
        st = -1;
        if (S >= 2) begin
            if (lvl == 0) begin
                st = 0;
            end
            for (int j = 1; j <= S - 2; j++) begin
                if (lvl == ceil_div(L * j, S - 1)) begin
                    st = j;
                end
            end
        end
        return st;
    endfunction

endpackage

// File: rtl/pg_cell.sv
// Prefix combine cell: (g,p) = (g_hi,p_hi) o (g_lo,p_lo). Grey cells (BLACK=0)
// drop the group propagate because the group is already fully resolved.
module pg_cell #(
    parameter int BLACK = 1
) (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);

    assign g = g_hi | (p_hi & g_lo);
    assign p = (BLACK != 0) ? (p_hi & p_lo) : 1'b0;

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Sklansky adder/subtractor with valid/ready flow control.
// Define PREFIX_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module prefix_adder_pipe
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PREFIX_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int L = num_levels(WIDTH);
    localparam int S = STAGES;

    // Flow control: stage j is ready when empty or when everything after it moves.
    logic [S-1:0] v_q;
    logic [S-1:0] rdy;
    logic [S-1:0] src_v;
    logic [S-1:0] ld;
    logic         rdy_chain;

    always_comb begin
        rdy_chain = out_ready;
        rdy       = '0;
        for (int j = S - 1; j >= 0; j--) begin
            rdy_chain = !v_q[j] || rdy_chain;
            rdy[j]    = rdy_chain;
        end
    end

    always_comb begin
        src_v    = '0;
        src_v[0] = in_valid;
        for (int j = 1; j < S; j++) begin
            src_v[j] = v_q[j-1];
        end
    end

    // Data loads only with a real beat, so an emptied pipe keeps its outputs quiet.
    assign ld        = rdy & src_v;
    assign in_ready  = rdy[0];
    assign out_valid = v_q[S-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= (v_q & ~rdy) | (src_v & rdy);
        end
    end

    // Per-level datapath: gc/pc are combinational results, gr/pr after the optional register.
    // bc carries the bit propagates for the sum, cc carries c0.
    logic [WIDTH-1:0] gc [0:L];
    logic [WIDTH-1:0] pc [0:L];
    logic [WIDTH-1:0] bc [0:L];
    logic             cc [0:L];
    logic [WIDTH-1:0] gr [0:L];
    logic [WIDTH-1:0] pr [0:L];
    logic [WIDTH-1:0] br [0:L];
    logic             cr [0:L];

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g0;
    logic [WIDTH-1:0] p0;
    logic             c0;

    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub | cin;
        p0    = a ^ b_eff;
        g0    = a & b_eff;
        g0[0] = g0[0] | (p0[0] & c0);
    end

    assign gc[0] = g0;
    assign pc[0] = p0;
    assign bc[0] = p0;
    assign cc[0] = c0;

    for (genvar lvl = 1; lvl <= L; lvl++) begin : g_level
        localparam int K = lvl - 1;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i >> K) % 2) == 1) begin : g_cell
                localparam int J = ((i >> K) << K) - 1;
                logic g_new;
                logic p_new;
                pg_cell #(
                    .BLACK((i >= (2 << K)) ? 1 : 0)
                ) u_cell (
                    .g_hi (gr[lvl-1][i]),
                    .p_hi (pr[lvl-1][i]),
                    .g_lo (gr[lvl-1][J]),
                    .p_lo (pr[lvl-1][J]),
                    .g    (g_new),
                    .p    (p_new)
                );
                assign gc[lvl][i] = g_new;
                assign pc[lvl][i] = p_new;
            end else begin : g_pass
                assign gc[lvl][i] = gr[lvl-1][i];
                assign pc[lvl][i] = pr[lvl-1][i];
            end
        end
        assign bc[lvl] = br[lvl-1];
        assign cc[lvl] = cr[lvl-1];
    end

    for (genvar lvl = 0; lvl <= L; lvl++) begin : g_stage
        localparam int ST = stage_after_level(lvl, L, S);
        if (ST >= 0) begin : g_reg
            logic [WIDTH-1:0] g_q;
            logic [WIDTH-1:0] p_q;
            logic [WIDTH-1:0] b_q;
            logic             c_q;
            always_ff @(posedge clk) begin
                if (ld[ST]) begin
                    g_q <= gc[lvl];
                    p_q <= pc[lvl];
                    b_q <= bc[lvl];
                    c_q <= cc[lvl];
                end
            end
            assign gr[lvl] = g_q;
            assign pr[lvl] = p_q;
            assign br[lvl] = b_q;
            assign cr[lvl] = c_q;
        end else begin : g_wire
            assign gr[lvl] = gc[lvl];
            assign pr[lvl] = pc[lvl];
            assign br[lvl] = bc[lvl];
            assign cr[lvl] = cc[lvl];
        end
    end

    // After the last level gr[L][i] is the carry out of bit i.
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             unused_p;

    assign sum_d    = br[L] ^ {gr[L][WIDTH-2:0], cr[L]};
    assign cout_d   = gr[L][WIDTH-1];
    assign unused_p = ^pr[L];

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (ld[S-1]) begin
            sum  <= sum_d;
            cout <= cout_d;
        end
    end

`ifdef PREFIX_ADDER_OVF_EN
    logic ovf_d;
    assign ovf_d = gr[L][WIDTH-1] ^ gr[L][WIDTH-2];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ld[S-1]) begin
            ovf <= ovf_d;
        end
    end
`endif

endmodule

// File: doc/prefix_adder_pipe.md
# prefix_adder_pipe

- Parametrised, pipelined parallel-prefix adder/subtractor for the arithmetic-tree library.
- Generalises the fixed 8-bit sparse prefix adder to any `WIDTH`, adding:
  - carry-in and carry-out;
  - add/subtract mode;
  - configurable register stages between prefix levels;
  - a valid/ready handshake with per-stage bubble collapse.
- Sits between operand-issue logic and the result writeback path in datapaths that need a high-frequency wide adder.

## Interface

**Parameters**
- `WIDTH`, default 32: operand and sum width, power of two, 4..128.
- `STAGES`, default 2: register stages, 1..`$clog2(WIDTH)`+1; equals latency.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, **synchronous, active-high**.
- `in_valid`, in, 1: operand beat present.
- `in_ready`, out, 1: block accepts the beat this cycle.
- `a`, in, `WIDTH`: operand A.
- `b`, in, `WIDTH`: operand B.
- `cin`, in, 1: carry-in; ignored when `sub`=1.
- `sub`, in, 1: 1 selects A−B.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: consumer accepts the result.
- `sum`, out, `WIDTH`: result.
- `cout`, out, 1: carry-out; for subtract, 1 means no borrow.
- `ovf`, out, 1: signed overflow; present only with `PREFIX_ADDER_OVF_EN`.

## Operation

- **Operand pre-processing:** `b_eff = sub ? ~b : b`, `c0 = sub ? 1 : cin`.
- **Bit generate/propagate:** `g_i = a_i & b_eff_i`, `p_i = a_i ^ b_eff_i`.
  - `c0` is folded in as bit −1 generate: `g_0' = g_0 | (p_0 & c0)`.
- **Prefix network:** Sklansky, `L = $clog2(WIDTH)` levels.
  - At level k, bit i with bit k of i set combines with the group ending at `(i >> k << k) − 1`.
  - A black cell is used where group propagate is still needed; otherwise a grey cell.
- **Sum and carry:**
  - `sum_i = p_i ^ C_{i−1}`, with `C_{−1} = c0`.
  - `cout = C_{WIDTH−1}`.
- **Arithmetic:** modulo 2^`WIDTH`; no saturation.
- **Pipeline stages:**
  - Stage 0 registers p/g plus `c0`.
  - Remaining `STAGES−1` registers are placed after prefix level `ceil(L*j/(STAGES−1))`, j=1..`STAGES−1`.
  - The final register holds `sum`/`cout`/`ovf`.
  - With `STAGES`=1, the only register is the output register, and the whole tree is combinational before it.
- **Per-stage state:** each stage j has a valid bit `v[j]`.
  - Stage j loads when `!v[j] || adv[j+1]`, where `adv[STAGES] = out_ready`.
  - `in_ready = !v[0] || adv[1]`; it is combinational from downstream.
  - Bubbles collapse: an empty stage fills even when the output is stalled.
- **Handshakes:**
  - Input transfer on `in_valid && in_ready`.
  - Output transfer on `out_valid && out_ready`.
  - `out_valid = v[STAGES−1]`.
- **Data integrity:**
  - Data registers update only on load; data is held stable while `out_valid && !out_ready`.
  - Registers in an empty stage are not cleared and may hold stale data.

## Timing

- **Latency:** `STAGES` cycles from accepted input to `out_valid`, with no stall.
- **Throughput:** one result per cycle when `out_ready`=1.
- **Reset:**
  - All `v` bits are 0 on the first edge with `rst`=1.
  - `out_valid`=0; `sum`, `cout` and `ovf` are 0.
  - `in_ready`=1 in the cycle after reset deasserts.
- **Reset mid-operation:** in-flight beats are dropped, no output appears for them, and the output registers clear.
- **Simultaneous input and output transfer with a full pipeline:** both occur in the same cycle and no beat is lost.
- **Back-pressure:**
  - `out_ready` held low for N cycles fills at most `STAGES` beats.
  - `in_ready` falls only when every stage is valid.

## Configuration

- `PREFIX_ADDER_OVF_EN` **defined:**
  - Port `ovf` exists.
  - `ovf = C_{WIDTH−1} ^ C_{WIDTH−2}`, computed in the last stage and registered with `sum`.
- `PREFIX_ADDER_OVF_EN` **undefined:**
  - Port `ovf` is absent.
  - No overflow logic is built; everything else is unchanged.

## Structure

- **Shared package `prefix_adder_pkg`:**
  - `function automatic int stage_after_level(int lvl, int L, int S)` (register placement).
  - localparam helpers for the level count.
- **Sub-module `pg_cell`:**
  - Parameter `BLACK` (0/1); inputs `g_hi`, `p_hi`, `g_lo`, `p_lo`; outputs `g`, `p`.
  - Output `p` is tied 0 when `BLACK`=0.
  - The prefix tree is generated by nested generate loops instantiating `pg_cell`.

## Test plan

All scenarios use `WIDTH`=8, `STAGES`=2 unless noted.

1. After reset, `in_valid`=1, a=0xFF, b=0x01, cin=0, sub=0 → two cycles later out_valid=1, sum=0x00, cout=1.
2. a=0x05, b=0x07, sub=1 → sum=0xFE, cout=0; a=0x07, b=0x05, sub=1 → sum=0x02, cout=1.
3. With `PREFIX_ADDER_OVF_EN`: a=0x7F, b=0x01 → sum=0x80, ovf=1; a=0x80, b=0xFF → sum=0x7F, cout=1, ovf=1.
4. Stream 4 beats with out_ready=0:
   - in_ready drops after 2 beats are accepted.
   - Raising out_ready drains them in order, one per cycle, while new beats are accepted in the same cycles.
5. Assert rst with 2 beats in flight → out_valid=0 and sum=0 the next cycle; neither beat ever appears.
6. `WIDTH`=64, `STAGES`=7, 10k random a/b/cin/sub with random valid/ready stalls → every result matches the reference model (a + b_eff + c0) in order, with latency exactly 7 when unstalled.
